// File: rtl/fetch_bundle_queue.sv
// Fetch front-end: owns the fetch PC, issues bundle-wide instruction requests
// and buffers returned bundles in a small queue decoupled from DECODE.
module fetch_bundle_queue #(
  parameter int unsigned          PC_WIDTH    = 16,
  parameter int unsigned          FETCH_WIDTH = 4,
  parameter int unsigned          DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  localparam int unsigned         LANE_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int unsigned         CNT_W       = $clog2(DEPTH) + 1,
  localparam int unsigned         DATA_W      = FETCH_WIDTH * PC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exter_pc_en,
  input  logic [PC_WIDTH-1:0]    exter_pc,
  input  logic                   redirect_en,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   jump_en,
  input  logic [PC_WIDTH-1:0]    jump_pc,
  input  logic                   fetch_hold,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   bp_taken,
  input  logic [LANE_W-1:0]      bp_lane,
  input  logic [PC_WIDTH-1:0]    bp_target,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [PC_WIDTH-1:0]    deq_pc,
  output logic [DATA_W-1:0]      deq_inst,
  output logic [FETCH_WIDTH-1:0] deq_lane_valid,
  output logic [FETCH_WIDTH-1:0] deq_pred,
  output logic [CNT_W-1:0]       occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
  logic                   inflight_q, inflight_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [PC_WIDTH-1:0]    ent_pc_q   [DEPTH];
  logic [PC_WIDTH-1:0]    ent_pc_d   [DEPTH];
  logic [DATA_W-1:0]      ent_inst_q [DEPTH];
  logic [DATA_W-1:0]      ent_inst_d [DEPTH];
  logic [FETCH_WIDTH-1:0] ent_lv_q   [DEPTH];
  logic [FETCH_WIDTH-1:0] ent_lv_d   [DEPTH];
  logic [FETCH_WIDTH-1:0] ent_pred_q [DEPTH];
  logic [FETCH_WIDTH-1:0] ent_pred_d [DEPTH];

  logic                   flush, kill, resp_live, taken_live;
  logic                   not_empty, deq_fire, issue;
  logic [CNT_W-1:0]       reserved;
  logic [FETCH_WIDTH-1:0] resp_lv, resp_pred;

  always_comb begin
    flush      = exter_pc_en | redirect_en;
    kill       = flush | jump_en;
    resp_live  = inflight_q & ~kill;
    taken_live = resp_live & bp_taken;
    not_empty  = (count_q != '0);
    deq_fire   = not_empty & deq_ready & ~flush;
    // Slots already promised: queued entries plus the response still in flight.
    reserved   = count_q + CNT_W'(inflight_q) - CNT_W'(deq_fire);
    issue      = ~rst & ~fetch_hold & ~kill & ~taken_live & (reserved < CNT_W'(DEPTH));

    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      resp_lv[i]   = ~bp_taken | (LANE_W'(i) <= bp_lane);
      resp_pred[i] = bp_taken & (LANE_W'(i) == bp_lane);
    end
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ent_pc_d   = ent_pc_q;
    ent_inst_d = ent_inst_q;
    ent_lv_d   = ent_lv_q;
    ent_pred_d = ent_pred_q;

    if (issue) begin
      req_pc_d = pc_q;
    end

    if (exter_pc_en)      pc_d = exter_pc;
    else if (redirect_en) pc_d = redirect_pc;
    else if (jump_en)     pc_d = jump_pc;
    else if (taken_live)  pc_d = bp_target;
    else if (issue)       pc_d = pc_q + PC_WIDTH'(FETCH_WIDTH);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (resp_live) begin
        ent_pc_d[tail_q]   = req_pc_q;
        ent_inst_d[tail_q] = imem_rdata;
        ent_lv_d[tail_q]   = resp_lv;
        ent_pred_d[tail_q] = resp_pred;
        tail_d             = tail_q + PTR_W'(1);
      end
      if (deq_fire) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(resp_live) - CNT_W'(deq_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset: outputs are zeroed whenever the queue is empty.
  always_ff @(posedge clk) begin
    ent_pc_q   <= ent_pc_d;
    ent_inst_q <= ent_inst_d;
    ent_lv_q   <= ent_lv_d;
    ent_pred_q <= ent_pred_d;
  end

  always_comb begin
    imem_req       = issue;
    imem_addr      = pc_q;
    deq_valid      = not_empty;
    occupancy      = count_q;
    deq_pc         = not_empty ? ent_pc_q[head_q]   : '0;
    deq_inst       = not_empty ? ent_inst_q[head_q] : '0;
    deq_lane_valid = not_empty ? ent_lv_q[head_q]   : '0;
    deq_pred       = not_empty ? ent_pred_q[head_q] : '0;
  end

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Self-checking bench for fetch_bundle_queue: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_fetch_bundle_queue;

  localparam int unsigned PW    = 16;
  localparam int unsigned FW    = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          exter_pc_en;
  logic [15:0]   exter_pc;
  logic          redirect_en;
  logic [15:0]   redirect_pc;
  logic          jump_en;
  logic [15:0]   jump_pc;
  logic          fetch_hold;
  logic          imem_req;
  logic [15:0]   imem_addr;
  logic [63:0]   imem_rdata;
  logic          bp_taken;
  logic [1:0]    bp_lane;
  logic [15:0]   bp_target;
  logic          deq_ready;
  logic          deq_valid;
  logic [15:0]   deq_pc;
  logic [63:0]   deq_inst;
  logic [3:0]    deq_lane_valid;
  logic [3:0]    deq_pred;
  logic [2:0]    occupancy;

  fetch_bundle_queue #(
    .PC_WIDTH   (PW),
    .FETCH_WIDTH(FW),
    .DEPTH      (DEPTH),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .exter_pc_en   (exter_pc_en),
    .exter_pc      (exter_pc),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .jump_en       (jump_en),
    .jump_pc       (jump_pc),
    .fetch_hold    (fetch_hold),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .bp_taken      (bp_taken),
    .bp_lane       (bp_lane),
    .bp_target     (bp_target),
    .deq_ready     (deq_ready),
    .deq_valid     (deq_valid),
    .deq_pc        (deq_pc),
    .deq_inst      (deq_inst),
    .deq_lane_valid(deq_lane_valid),
    .deq_pred      (deq_pred),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [63:0] inst;
    logic [3:0]  lv;
    logic [3:0]  pred;
  } bundle_t;

  bundle_t     mq[$];
  logic [15:0] m_pc;
  logic        m_inf;
  logic [15:0] m_addr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_flush();
    return exter_pc_en || redirect_en;
  endfunction

  function automatic bit m_live();
    return m_inf && !(m_flush() || jump_en);
  endfunction

  function automatic bit m_dfire();
    return (mq.size() > 0) && deq_ready && !m_flush();
  endfunction

  // A request goes out only if every promised slot still fits in the queue.
  function automatic bit m_req();
    int slots;
    slots = mq.size() + int'(m_inf) - int'(m_dfire());
    return !rst && !fetch_hold && !(m_flush() || jump_en) &&
           !(m_live() && bp_taken) && (slots < int'(DEPTH));
  endfunction

  task automatic model_check();
    bit er;
    er = m_req();
    chk("imem_req", imem_req, er);
    if (er) chk("imem_addr", imem_addr, m_pc);
    chk("deq_valid", deq_valid, mq.size() > 0);
    chk("occupancy", occupancy, mq.size());
    if (mq.size() > 0) begin
      chk("deq_pc", deq_pc, mq[0].pc);
      chk("deq_inst", deq_inst, mq[0].inst);
      chk("deq_lane_valid", deq_lane_valid, mq[0].lv);
      chk("deq_pred", deq_pred, mq[0].pred);
    end
  endtask

  task automatic model_update();
    bit      live, taken, dfire, req;
    bundle_t b;
    if (rst) begin
      m_pc  = 16'h0000;
      m_inf = 1'b0;
      mq.delete();
    end else begin
      live  = m_live();
      taken = live && bp_taken;
      dfire = m_dfire();
      req   = m_req();
      if (m_flush()) mq.delete();
      else begin
        if (dfire) void'(mq.pop_front());
        if (live) begin
          b.pc   = m_addr;
          b.inst = imem_rdata;
          b.lv   = bp_taken ? 4'((5'd1 << (bp_lane + 3'd1)) - 5'd1) : 4'hF;
          b.pred = bp_taken ? 4'(1 << bp_lane) : 4'h0;
          mq.push_back(b);
        end
      end
      m_inf  = req;
      m_addr = m_pc;
      if (exter_pc_en)      m_pc = exter_pc;
      else if (redirect_en) m_pc = redirect_pc;
      else if (jump_en)     m_pc = jump_pc;
      else if (taken)       m_pc = bp_target;
      else if (req)         m_pc = m_pc + 16'd4;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    imem_rdata = {$urandom, $urandom};
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    exter_pc_en = 0; exter_pc = '0;
    redirect_en = 0; redirect_pc = '0;
    jump_en = 0; jump_pc = '0;
    fetch_hold = 0;
    bp_taken = 0; bp_lane = '0; bp_target = '0;
    deq_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  int nreq;

  initial begin
    idle_inputs();
    rst = 1;
    imem_rdata = {$urandom, $urandom};
    @(posedge clk);
    model_update();
    #1;

    // 1: reset state and sequential fetch
    do_reset();
    deq_ready = 1;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (k == 0) begin
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_deq_pc", deq_pc, 0);
        chk("rst_deq_inst", deq_inst, 0);
        chk("rst_deq_lv", deq_lane_valid, 0);
        chk("rst_deq_pred", deq_pred, 0);
      end
      if (k < 4) begin
        chk("seq_req", imem_req, 1);
        chk("seq_addr", imem_addr, 16'(4 * k));
      end
      if (k >= 2 && k < 5) begin
        chk("seq_deq_valid", deq_valid, 1);
        chk("seq_deq_pc", deq_pc, 16'(4 * (k - 2)));
        chk("seq_deq_lv", deq_lane_valid, 4'b1111);
      end
      tick();
    end

    // 2: backpressure
    do_reset();
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      if (imem_req) nreq++;
      tick();
    end
    chk("bp_req_count", nreq, 4);
    settle();
    chk("bp_full_occ", occupancy, 4);
    chk("bp_full_req", imem_req, 0);
    tick();
    deq_ready = 1;
    nreq = 0;
    settle();
    chk("bp_release_req", imem_req, 1);
    if (imem_req) nreq++;
    tick();
    deq_ready = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (imem_req) nreq++;
      tick();
    end
    chk("bp_one_more_req", nreq, 1);

    // 3: predicted-taken branch
    do_reset();
    deq_ready = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        bp_taken = 1; bp_lane = 2'd1; bp_target = 16'h0040;
      end
      settle();
      if (k == 3) chk("tk_no_addr12", imem_req, 0);
      if (k == 4) begin
        chk("tk_req", imem_req, 1);
        chk("tk_addr", imem_addr, 16'h0040);
        chk("tk_deq_pc", deq_pc, 16'h0008);
        chk("tk_lv", deq_lane_valid, 4'b0011);
        chk("tk_pred", deq_pred, 4'b0010);
      end
      tick();
      bp_taken = 0;
    end

    // 4: misprediction flush
    do_reset();
    for (int k = 0; k < 4; k++) cyc();
    redirect_en = 1; redirect_pc = 16'h0100;
    settle();
    chk("mp_occ_before", occupancy, 3);
    chk("mp_req_killed", imem_req, 0);
    tick();
    redirect_en = 0;
    settle();
    chk("mp_occ_after", occupancy, 0);
    chk("mp_deq_valid", deq_valid, 0);
    chk("mp_addr", imem_addr, 16'h0100);
    tick();
    settle();
    chk("mp_no_stale_enq", occupancy, 0);
    tick();

    // 5: jump with hold
    do_reset();
    cyc();
    cyc();
    fetch_hold = 1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("jh_no_req", imem_req, 0);
      if (k > 0) chk("jh_occ", occupancy, 2);
      tick();
    end
    fetch_hold = 0;
    jump_en = 1; jump_pc = 16'h0200;
    settle();
    chk("jh_jump_occ", occupancy, 2);
    tick();
    jump_en = 0;
    settle();
    chk("jh_occ_kept", occupancy, 2);
    chk("jh_req", imem_req, 1);
    chk("jh_addr", imem_addr, 16'h0200);
    tick();

    // 6: priority and wrap
    do_reset();
    deq_ready = 1;
    redirect_en = 1; redirect_pc = 16'h0300;
    jump_en = 1; jump_pc = 16'h0500;
    cyc();
    redirect_en = 0; jump_en = 0;
    settle();
    chk("pri_addr", imem_addr, 16'h0300);
    tick();
    exter_pc_en = 1; exter_pc = 16'hFFFC;
    cyc();
    exter_pc_en = 0;
    settle();
    chk("wrap_addr0", imem_addr, 16'hFFFC);
    tick();
    settle();
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr1", imem_addr, 16'h0000);
    tick();

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 299) == 0);
      exter_pc_en = ($urandom_range(0, 99) == 0);
      exter_pc    = 16'($urandom);
      redirect_en = ($urandom_range(0, 24) == 0);
      redirect_pc = 16'($urandom);
      jump_en     = ($urandom_range(0, 24) == 0);
      jump_pc     = 16'($urandom);
      fetch_hold  = ($urandom_range(0, 5) == 0);
      deq_ready   = ($urandom_range(0, 9) < 7);
      bp_taken    = ($urandom_range(0, 4) == 0);
      bp_lane     = 2'($urandom);
      bp_target   = 16'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
